button_event_queue: RTL



---
 rtl/button_event_queue_if.sv | 18 +
 rtl/button_event_queue.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/button_event_queue_if.sv
// CPU read port of the button event queue: first-word-fall-through head word plus a one-cycle pop strobe.
interface button_event_queue_if;
    logic        readStrobe;
    logic [15:0] inputData;
    logic        inputValid;

    modport master (
        output readStrobe,
        input  inputData,
        input  inputValid
    );

    modport slave (
        input  readStrobe,
        output inputData,
        output inputValid
    );
endinterface

// File: rtl/button_event_queue.sv
// Synchronizes and debounces four push-buttons, turns press/release edges into event words
// and queues them in a small first-word-fall-through FIFO popped by the CPU.
module button_event_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           button,
    button_event_queue_if.slave  bus,
    output logic [3:0]           buttonState,
    output logic                 overflow
);

    localparam int unsigned NUM_BUTTONS = 4;
    localparam int unsigned CNT_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned AW          = $clog2(FIFO_DEPTH);
    localparam int unsigned PW          = AW + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]    DEPTH_P = PW'(FIFO_DEPTH);

    typedef struct packed {
        logic       press;
        logic [1:0] index;
    } event_t;

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [CNT_W-1:0] cnt [NUM_BUTTONS];
    logic [3:0]       edge_flag;
    logic [3:0]       pend_valid;
    logic [3:0]       pend_press;

    logic [3:0]       grant_c;
    logic             push_c;
    event_t           push_entry_c;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    occupancy_c;
    logic             empty_c;
    logic             full_c;
    logic             pop_c;
    logic             write_c;
    logic             drop_c;
    event_t           mem [FIFO_DEPTH];
    event_t           head_c;

    // Two-flop synchronizer for the raw asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: a new level must persist DEBOUNCE_CYCLES cycles before it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable    <= '0;
            edge_flag <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            edge_flag <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else begin
                    stable[i]    <= sync2[i];
                    cnt[i]       <= '0;
                    edge_flag[i] <= 1'b1;
                end
            end
        end
    end

    // Pending event per button; the debounce interval guarantees it drains before the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= '0;
            pend_press <= '0;
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (edge_flag[i]) begin
                    pend_valid[i] <= 1'b1;
                    pend_press[i] <= stable[i];
                end else if (grant_c[i]) begin
                    pend_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Fixed-priority arbiter: lowest pending index enqueues first, one per cycle.
    always_comb begin
        grant_c      = '0;
        push_c       = 1'b0;
        push_entry_c = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (pend_valid[i] && !push_c) begin
                grant_c[i]         = 1'b1;
                push_c             = 1'b1;
                push_entry_c.press = pend_press[i];
                push_entry_c.index = 2'(i);
            end
        end
    end

    // FIFO control; a pop in the same cycle frees the slot a full-queue push needs.
    always_comb begin
        occupancy_c = wr_ptr - rd_ptr;
        empty_c     = (occupancy_c == '0);
        full_c      = (occupancy_c == DEPTH_P);
        pop_c       = bus.readStrobe && !empty_c;
        write_c     = push_c && (!full_c || pop_c);
        drop_c      = push_c && full_c && !pop_c;
    end

    always_ff @(posedge clk) begin
        if (write_c) begin
            mem[wr_ptr[AW-1:0]] <= push_entry_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (write_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head_c         = mem[rd_ptr[AW-1:0]];
    assign bus.inputData  = empty_c ? 16'h0000 : {13'd0, head_c};
    assign bus.inputValid = !empty_c;
    assign buttonState    = stable;

endmodule
